// File: rtl/if_queue_if.sv
// Fetch-to-decode queue bus: the fetch push port, the flush line, the decode pop port and status.
// The queue module takes the slave side. The producer, or a bench, takes the master side.
interface if_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Push side (fetch -> queue)
  logic            i_wr_valid;
  logic [XLEN-1:0] i_wr_pc;
  logic [31:0]     i_wr_instr;
  logic            i_flush;

  // Pop side (queue -> decode)
  logic            i_rd_ready;
  logic            o_rd_valid;
  logic [XLEN-1:0] o_rd_pc;
  logic [31:0]     o_rd_instr;

  // Status
  logic            o_halt;
  logic [CW-1:0]   o_count;
  logic            o_overflow;

  modport master (
    output i_wr_valid, i_wr_pc, i_wr_instr, i_flush, i_rd_ready,
    input  o_rd_valid, o_rd_pc, o_rd_instr, o_halt, o_count, o_overflow
  );

  modport slave (
    input  i_wr_valid, i_wr_pc, i_wr_instr, i_flush, i_rd_ready,
    output o_rd_valid, o_rd_pc, o_rd_instr, o_halt, o_count, o_overflow
  );
endinterface

// File: rtl/if_queue.sv
// Instruction fetch queue: DEPTH-entry circular FIFO of {pc, instr} between fetch and decode.
// o_halt is a registered early-full signal. It leaves one slot for the fetch that is already in flight.
module if_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic      i_clk,
  input  logic      i_rst,
  if_queue_if.slave q
);
  localparam int              PW     = $clog2(DEPTH);
  localparam int              CW     = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0]   HALT_C = CW'(DEPTH - 1);

  // Handshake: the write side has no ready signal. A word is taken when i_wr_valid is high
  // and there is room or a pop is happening. Otherwise the word is dropped and o_overflow is set.
  // The read side transfers when o_rd_valid && i_rd_ready. A flush overrides both sides.
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0] count_q, count_nxt;
  logic          halt_q, halt_nxt;
  logic          ovf_q, ovf_nxt;
  logic          not_empty, not_full;
  logic          push, pop, drop;

  always_comb begin
    not_empty = (count_q != '0);
    not_full  = (count_q != FULL_C);
    pop       = not_empty && q.i_rd_ready && !q.i_flush;
    push      = q.i_wr_valid && !q.i_flush && (not_full || pop);
    drop      = q.i_wr_valid && !q.i_flush && !not_full && !pop;
  end

  always_comb begin
    count_nxt  = count_q;
    wr_ptr_nxt = wr_ptr_q;
    rd_ptr_nxt = rd_ptr_q;
    ovf_nxt    = ovf_q || drop;
    if (q.i_flush) begin
      count_nxt  = '0;
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end else begin
      if (push) wr_ptr_nxt = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_nxt = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_nxt = count_q + CW'(1);
        2'b01:   count_nxt = count_q - CW'(1);
        default: count_nxt = count_q;
      endcase
    end
    // A flush drives count_nxt to zero, so halt is also cleared after a flush.
    halt_nxt = (count_nxt >= HALT_C);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      halt_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_nxt;
      rd_ptr_q <= rd_ptr_nxt;
      count_q  <= count_nxt;
      halt_q   <= halt_nxt;
      ovf_q    <= ovf_nxt;
    end
  end

  // Storage has no reset. It is only visible through the head while count is nonzero.
  always_ff @(posedge i_clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= q.i_wr_pc;
      instr_mem[wr_ptr_q] <= q.i_wr_instr;
    end
  end

  always_comb begin
    q.o_rd_valid = not_empty;
    q.o_rd_pc    = not_empty ? pc_mem[rd_ptr_q]    : '0;
    q.o_rd_instr = not_empty ? instr_mem[rd_ptr_q] : '0;
    q.o_halt     = halt_q;
    q.o_count    = count_q;
    q.o_overflow = ovf_q;
  end
endmodule

// File: tb/tb_if_queue.sv
// Self-checking bench for if_queue. It keeps a reference queue of expected {pc, instr} entries
// and checks head data, count, halt and overflow against it every cycle.
module tb_if_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int W     = 64;

  logic i_clk;
  logic i_rst;
  int   checks;
  int   failures;

  logic [W-1:0] exp_q[$];
  logic         ovf_m;
  logic         halt_m;

  if_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  if_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .q     (bus)
  );

  // Clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compare every status output with the reference model. Called at the falling edge.
  task automatic check_outputs();
    int sz;
    sz = exp_q.size();
    check("count",    W'(bus.o_count), W'(sz));
    check("rd_valid", W'(bus.o_rd_valid), W'(sz != 0));
    check("halt",     W'(bus.o_halt), W'(halt_m));
    check("overflow", W'(bus.o_overflow), W'(ovf_m));
    if (sz == 0) check("empty_zero", {bus.o_rd_pc, bus.o_rd_instr}, '0);
    else         check("head",       {bus.o_rd_pc, bus.o_rd_instr}, exp_q[0]);
  endtask

  // Driver: check the outputs, apply one cycle of stimulus, update the model, then advance to the next falling edge.
  task automatic step(input logic wv, input logic [31:0] pc, input logic [31:0] ins,
                      input logic rr, input logic fl);
    int           sz;
    logic         pop_m;
    logic         push_m;
    logic [W-1:0] e;
    check_outputs();
    bus.i_wr_valid = wv;
    bus.i_wr_pc    = pc;
    bus.i_wr_instr = ins;
    bus.i_rd_ready = rr;
    bus.i_flush    = fl;
    sz     = exp_q.size();
    pop_m  = (sz != 0) && rr && !fl;
    push_m = wv && !fl && ((sz < DEPTH) || pop_m);
    if (pop_m) begin
      e = exp_q.pop_front();
      check("pop_data", {bus.o_rd_pc, bus.o_rd_instr}, e);
    end
    if (wv && !fl && (sz == DEPTH) && !pop_m) ovf_m = 1'b1;
    if (fl) exp_q.delete();
    else if (push_m) exp_q.push_back({pc, ins});
    halt_m = (exp_q.size() >= DEPTH - 1);
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ovf_m    = 1'b0;
    halt_m   = 1'b0;
    bus.i_wr_valid = 1'b0;
    bus.i_wr_pc    = '0;
    bus.i_wr_instr = '0;
    bus.i_rd_ready = 1'b0;
    bus.i_flush    = 1'b0;
    i_rst = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check_outputs();
    i_rst = 1'b1;

    // Push three entries with no pops. The queue holds 3 entries and halt is set.
    for (int i = 0; i < 3; i++) step(1'b1, 32'(i), 32'hA0 + 32'(i), 1'b0, 1'b0);
    check("r021_count", W'(bus.o_count), W'(3));
    check("r021_halt",  W'(bus.o_halt), W'(1));
    check("r021_head",  {bus.o_rd_pc, bus.o_rd_instr}, {32'h0, 32'hA0});

    // Fill the queue, then push and pop in the same cycle while full.
    step(1'b1, 32'h3, 32'hA3, 1'b0, 1'b0);
    step(1'b1, 32'h5, 32'hA5, 1'b1, 1'b0);
    check("r023_count", W'(bus.o_count), W'(4));
    check("r023_head",  W'(bus.o_rd_pc), W'(1));
    check("r023_ovf",   W'(bus.o_overflow), W'(0));
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Push one more entry than fits with no pop. The extra word is dropped and overflow sticks.
    for (int i = 0; i < 5; i++) step(1'b1, 32'(i), 32'hA0 + 32'(i), 1'b0, 1'b0);
    check("r022_count", W'(bus.o_count), W'(4));
    check("r022_ovf",   W'(bus.o_overflow), W'(1));
    check("r022_head",  W'(bus.o_rd_pc), W'(0));
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("r022_ovf_sticky", W'(bus.o_overflow), W'(1));

    // Flush with a push and a pop in the same cycle, then push the branch target.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h10 + 32'(i), 32'hB0 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'h20, 32'hBB, 1'b1, 1'b1);
    check("r024_count", W'(bus.o_count), W'(0));
    check("r024_valid", W'(bus.o_rd_valid), W'(0));
    check("r024_halt",  W'(bus.o_halt), W'(0));
    check("r024_data",  {bus.o_rd_pc, bus.o_rd_instr}, '0);
    check("r024_ovf",   W'(bus.o_overflow), W'(1));
    step(1'b1, 32'h40, 32'hC0, 1'b0, 1'b0);
    check("r024_target", {bus.o_rd_pc, bus.o_rd_instr}, {32'h40, 32'hC0});
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Streaming: push every cycle while decode is always ready. The pointers wrap several times.
    for (int i = 0; i < 11; i++) step(1'b1, 32'h100 + 32'(4 * i), 32'hD0 + 32'(i), 1'b1, 1'b0);
    check("r025_count", W'(bus.o_count), W'(1));
    check("r025_halt",  W'(bus.o_halt), W'(0));
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Assert reset mid-stream with two entries queued. The outputs must clear before the next edge.
    step(1'b1, 32'h200, 32'hE0, 1'b0, 1'b0);
    step(1'b1, 32'h204, 32'hE1, 1'b0, 1'b0);
    check("r026_pre_count", W'(bus.o_count), W'(2));
    bus.i_wr_valid = 1'b0;
    #2 i_rst = 1'b0;
    #1;
    check("r026_async_count", W'(bus.o_count), W'(0));
    check("r026_async_valid", W'(bus.o_rd_valid), W'(0));
    check("r026_async_data",  {bus.o_rd_pc, bus.o_rd_instr}, '0);
    check("r026_async_ovf",   W'(bus.o_overflow), W'(0));
    exp_q.delete();
    ovf_m  = 1'b0;
    halt_m = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    step(1'b1, 32'h300, 32'hF0, 1'b0, 1'b0);
    check("r020_first_push", {bus.o_rd_pc, bus.o_rd_instr}, {32'h300, 32'hF0});
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle(1);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 29) == 0));
    end
    check_outputs();

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
